mem_tiled_addresses_generator: RTL and testbench
================================================

// Module: mem_tiled_addresses_generator
// PURPOSE
//  Parametrised successor of the per-matrix address generators. Walks one matrix operand as a
//  grid of memory-word tiles, in column-major or row-major order, repeated N times. Pushes one
//  address per accepted cycle into the operand address FIFO. Honours FIFO back-pressure.
//  Sits between the config module (start/params) and the operand fetch FIFO.
// PARAMETERS
//  ADDR_WIDTH            16  width of base address and FIFO address; byte addressing
//  DIM_WIDTH             16  width of rows_i/cols_i/ld_i/repeat_i
//  DATA_WIDTH_BYTES      1   bytes per matrix element (power of 2)
//  MEM_DATA_WIDTH_BYTES  32  bytes per memory word (power of 2, >= DATA_WIDTH_BYTES)
//  ELEMENTS (localparam) MEM_DATA_WIDTH_BYTES/DATA_WIDTH_BYTES, elements per tile
// PORTS
//  clk          in   1           clock, all logic on posedge
//  reset        in   1           synchronous, active-high reset
//  start_i      in   1           start pulse; accepted only in IDLE
//  mode_i       in   1           0: tile-outer/row-inner (column walk); 1: row-outer/tile-inner
//  rows_i       in   DIM_WIDTH   number of matrix rows to walk
//  cols_i       in   DIM_WIDTH   number of matrix columns (elements) to walk
//  ld_i         in   DIM_WIDTH   leading dimension: elements between consecutive rows
//  repeat_i     in   DIM_WIDTH   passes over the whole matrix; 0 treated as 1
//  base_addr_i  in   ADDR_WIDTH  byte address of element (0,0)
//  fifo_addr    out  ADDR_WIDTH  address presented to FIFO
//  fifo_incr    out  1           FIFO push strobe
//  fifo_full    in   1           FIFO full; no push while high
//  busy_o       out  1           high in RUN and DONE
//  done_o       out  1           one-cycle pulse after the final push
// BEHAVIOUR
//  Reset: state=IDLE; all counters 0; fifo_addr=0, fifo_incr=0, busy_o=0, done_o=0.
//  Reset is honoured in any state, including mid-walk. It aborts the walk with no further pushes.
//  Config capture: on start_i in IDLE, latch mode, rows, cols, ld, base, repeat into internal registers.
//  Later input changes do not affect the walk. start_i outside IDLE is ignored.
//  Derived values:
//   - tiles = ceil(cols/ELEMENTS).
//   - row_step = ld*DATA_WIDTH_BYTES.
//   - tile_step = MEM_DATA_WIDTH_BYTES.
//   - reps = (repeat==0) ? 1 : repeat.
//  Address of (row r, tile t) = base + r*row_step + t*tile_step.
//  Computed incrementally: add row_step/tile_step, reload the row or tile start. No multipliers.
//  Address arithmetic is modulo 2^ADDR_WIDTH; wrap is silent.
//  FSM:
//   - IDLE -> RUN on start_i, if rows!=0 and cols!=0.
//   - IDLE -> DONE on start_i, if rows==0 or cols==0. This produces zero pushes.
//   - RUN: fifo_incr = !fifo_full (combinational from state and full); fifo_addr = current address register.
//   - RUN: on a push cycle, advance the counters. On a full cycle, hold everything.
//   - mode 0 order: row fastest, then tile, then rep.
//   - mode 1 order: tile fastest, then row, then rep.
//   - At the end of each rep, the address reloads to base.
//   - RUN -> DONE in the cycle after the push of (last row, last tile, last rep).
//   - DONE: done_o=1 for exactly one cycle -> IDLE.
//  Latency: start_i in cycle 0; first possible push in cycle 1. done_o is high in the cycle after the last push.
//  Total pushes = rows*tiles*reps. No address is skipped or duplicated under any fifo_full pattern.
//  fifo_incr is never high outside RUN. fifo_addr holds its value while fifo_full=1.
//  fifo_full must not change the address sequence, only its timing.
//  Counters:
//   - row_cnt, tile_cnt and rep_cnt are DIM_WIDTH wide.
//   - Completion is detected by compare-to-(limit-1) before incrementing, so limit = 2^DIM_WIDTH-1 works without overflow.
// TESTING (ELEMENTS=32, ADDR_WIDTH=16 unless stated)
//  1. mode 0, rows=3, cols=64, ld=64, base=0x0100, repeat=1, full=0
//     -> pushes 0x100,0x140,0x180,0x120,0x160,0x1A0 in cycles 1..6; done_o in cycle 7; busy_o low in cycle 8.
//  2. Same as 1 with mode 1 -> pushes 0x100,0x120,0x140,0x160,0x180,0x1A0.
//  3. Same as 1 with fifo_full high in cycles 2..4 -> no incr in cycles 2..4; fifo_addr=0x140 held;
//     the same 6 addresses are pushed in cycles 1, 5..9; done_o in cycle 10.
//  4. cols=40, rows=2, ld=40, repeat=0, mode 0, base=0 -> tiles=2; pushes 0x00,0x28,0x20,0x48; reps=1.
//     Then repeat=2 -> the same 4 addresses twice (8 pushes).
//  5. rows=0 -> no push, done_o one cycle after start.
//     base=0xFFE0, rows=2, cols=32, ld=32 -> pushes 0xFFE0, 0x0000 (wrap).
//  6. Reset asserted in cycle 3 of scenario 1 -> from cycle 4: IDLE, incr/busy/done=0.
//     A start_i during RUN is ignored. A fresh start_i after reset replays scenario 1 exactly.

Source files
------------

// File: rtl/mem_tiled_addresses_generator.sv
// Tiled operand address generator: walks a matrix as a grid of memory-word
// tiles, column- or row-major, N passes, pushing one address per free FIFO slot.
module mem_tiled_addresses_generator #(
  parameter int ADDR_WIDTH           = 16,
  parameter int DIM_WIDTH            = 16,
  parameter int DATA_WIDTH_BYTES     = 1,
  parameter int MEM_DATA_WIDTH_BYTES = 32
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start_i,
  input  logic                  mode_i,
  input  logic [DIM_WIDTH-1:0]  rows_i,
  input  logic [DIM_WIDTH-1:0]  cols_i,
  input  logic [DIM_WIDTH-1:0]  ld_i,
  input  logic [DIM_WIDTH-1:0]  repeat_i,
  input  logic [ADDR_WIDTH-1:0] base_addr_i,
  output logic [ADDR_WIDTH-1:0] fifo_addr,
  output logic                  fifo_incr,
  input  logic                  fifo_full,
  output logic                  busy_o,
  output logic                  done_o
);

  localparam int ELEMENTS = MEM_DATA_WIDTH_BYTES / DATA_WIDTH_BYTES;
  localparam int EL_SH    = $clog2(ELEMENTS);
  localparam int DB_SH    = $clog2(DATA_WIDTH_BYTES);

  localparam logic [ADDR_WIDTH-1:0] TILE_STEP = ADDR_WIDTH'(MEM_DATA_WIDTH_BYTES);
  localparam logic [DIM_WIDTH-1:0]  ONE       = DIM_WIDTH'(1);
  localparam logic [DIM_WIDTH:0]    EL_M1     = (DIM_WIDTH+1)'(ELEMENTS - 1);

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } state_t;

  state_t state_q, state_d;

  logic                  mode_q;
  logic [DIM_WIDTH-1:0]  rows_m1_q;
  logic [DIM_WIDTH-1:0]  tiles_m1_q;
  logic [DIM_WIDTH-1:0]  reps_m1_q;
  logic [ADDR_WIDTH-1:0] row_step_q;
  logic [ADDR_WIDTH-1:0] base_q;
  logic [ADDR_WIDTH-1:0] line_q;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic [DIM_WIDTH-1:0]  row_cnt;
  logic [DIM_WIDTH-1:0]  tile_cnt;
  logic [DIM_WIDTH-1:0]  rep_cnt;

  logic [DIM_WIDTH:0]    cols_ext;
  logic [DIM_WIDTH-1:0]  tiles_w;
  logic                  row_last;
  logic                  tile_last;
  logic                  rep_last;
  logic                  inner_last;
  logic                  outer_last;
  logic [ADDR_WIDTH-1:0] inner_step;
  logic [ADDR_WIDTH-1:0] outer_step;
  logic                  capture;

  // one extra bit keeps ceil() correct for cols near 2^DIM_WIDTH-1
  assign cols_ext = {1'b0, cols_i} + EL_M1;
  assign tiles_w  = DIM_WIDTH'(cols_ext >> EL_SH);

  assign row_last   = (row_cnt == rows_m1_q);
  assign tile_last  = (tile_cnt == tiles_m1_q);
  assign rep_last   = (rep_cnt == reps_m1_q);
  assign inner_last = mode_q ? tile_last : row_last;
  assign outer_last = mode_q ? row_last : tile_last;
  assign inner_step = mode_q ? TILE_STEP : row_step_q;
  assign outer_step = mode_q ? row_step_q : TILE_STEP;

  assign capture   = (state_q == IDLE) && start_i;
  assign fifo_incr = (state_q == RUN) && !fifo_full;
  assign fifo_addr = addr_q;
  assign busy_o    = (state_q != IDLE);
  assign done_o    = (state_q == DONE);

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: begin
        if (start_i) begin
          if (rows_i == '0 || cols_i == '0) state_d = DONE;
          else state_d = RUN;
        end
      end
      RUN: begin
        if (fifo_incr && inner_last && outer_last && rep_last)
          state_d = DONE;
      end
      DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) state_q <= IDLE;
    else state_q <= state_d;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      mode_q     <= 1'b0;
      rows_m1_q  <= '0;
      tiles_m1_q <= '0;
      reps_m1_q  <= '0;
      row_step_q <= '0;
      base_q     <= '0;
      line_q     <= '0;
      addr_q     <= '0;
      row_cnt    <= '0;
      tile_cnt   <= '0;
      rep_cnt    <= '0;
    end else if (capture) begin
      mode_q     <= mode_i;
      rows_m1_q  <= rows_i - ONE;
      tiles_m1_q <= tiles_w - ONE;
      reps_m1_q  <= (repeat_i == '0) ? '0 : repeat_i - ONE;
      row_step_q <= ADDR_WIDTH'(ld_i) << DB_SH;
      base_q     <= base_addr_i;
      line_q     <= base_addr_i;
      addr_q     <= base_addr_i;
      row_cnt    <= '0;
      tile_cnt   <= '0;
      rep_cnt    <= '0;
    end else if (fifo_incr) begin
      if (!inner_last) begin
        if (mode_q) tile_cnt <= tile_cnt + ONE;
        else row_cnt <= row_cnt + ONE;
        addr_q <= addr_q + inner_step;
      end else if (!outer_last) begin
        // line_q tracks the first address of the current outer line
        if (mode_q) begin
          tile_cnt <= '0;
          row_cnt  <= row_cnt + ONE;
        end else begin
          row_cnt  <= '0;
          tile_cnt <= tile_cnt + ONE;
        end
        line_q <= line_q + outer_step;
        addr_q <= line_q + outer_step;
      end else if (!rep_last) begin
        row_cnt  <= '0;
        tile_cnt <= '0;
        rep_cnt  <= rep_cnt + ONE;
        line_q   <= base_q;
        addr_q   <= base_q;
      end else begin
        row_cnt  <= '0;
        tile_cnt <= '0;
        rep_cnt  <= '0;
      end
    end
  end

endmodule

// File: tb/tb_mem_tiled_addresses_generator.sv
// Scoreboard bench for mem_tiled_addresses_generator
// (ELEMENTS=32, ADDR_WIDTH=16).
module tb_mem_tiled_addresses_generator;

  localparam int AW = 16;
  localparam int DW = 16;

  logic          clk = 1'b0;
  logic          reset;
  logic          start_i;
  logic          mode_i;
  logic [DW-1:0] rows_i;
  logic [DW-1:0] cols_i;
  logic [DW-1:0] ld_i;
  logic [DW-1:0] repeat_i;
  logic [AW-1:0] base_addr_i;
  logic [AW-1:0] fifo_addr;
  logic          fifo_incr;
  logic          fifo_full;
  logic          busy_o;
  logic          done_o;

  always #5 clk = ~clk;

  mem_tiled_addresses_generator #(
    .ADDR_WIDTH(AW),
    .DIM_WIDTH(DW),
    .DATA_WIDTH_BYTES(1),
    .MEM_DATA_WIDTH_BYTES(32)
  ) dut (
    .clk(clk),
    .reset(reset),
    .start_i(start_i),
    .mode_i(mode_i),
    .rows_i(rows_i),
    .cols_i(cols_i),
    .ld_i(ld_i),
    .repeat_i(repeat_i),
    .base_addr_i(base_addr_i),
    .fifo_addr(fifo_addr),
    .fifo_incr(fifo_incr),
    .fifo_full(fifo_full),
    .busy_o(busy_o),
    .done_o(done_o)
  );

  int n_checks = 0;
  int n_fail   = 0;

  logic [AW-1:0] exp_q[$];
  logic [AW-1:0] obs_q[$];
  int            obs_cyc[$];
  bit            incr_log[64];
  bit            busy_log[64];
  bit            done_log[64];
  logic [AW-1:0] addr_log[64];
  int            done_cyc;

  // Reference order computed directly from the (row, tile) coordinates.
  task automatic push_model(input bit m, input int rows, input int cols,
                            input int ld, input int base, input int rep);
    int tiles;
    int reps;
    tiles = (cols + 31) / 32;
    reps  = (rep == 0) ? 1 : rep;
    for (int p = 0; p < reps; p++) begin
      if (!m) begin
        for (int t = 0; t < tiles; t++)
          for (int r = 0; r < rows; r++)
            exp_q.push_back(AW'(base + r * ld + t * 32));
      end else begin
        for (int r = 0; r < rows; r++)
          for (int t = 0; t < tiles; t++)
            exp_q.push_back(AW'(base + r * ld + t * 32));
      end
    end
  endtask

  // Starts a walk in cycle 0 and logs outputs sampled mid-cycle.
  task automatic run(input bit m, input int rows, input int cols,
                     input int ld, input int base, input int rep,
                     input logic [63:0] full_mask, input int reset_cyc,
                     input int restart_cyc, input int ncyc);
    obs_q.delete();
    obs_cyc.delete();
    done_cyc = -1;
    for (int i = 0; i < 64; i++) begin
      incr_log[i] = 1'b0;
      busy_log[i] = 1'b0;
      done_log[i] = 1'b0;
      addr_log[i] = '0;
    end
    @(negedge clk);
    start_i     = 1'b1;
    mode_i      = m;
    rows_i      = DW'(rows);
    cols_i      = DW'(cols);
    ld_i        = DW'(ld);
    base_addr_i = AW'(base);
    repeat_i    = DW'(rep);
    fifo_full   = full_mask[0];
    for (int c = 1; c < ncyc; c++) begin
      @(posedge clk);
      #1;
      start_i = (c == restart_cyc);
      reset   = (c == reset_cyc);
      if (c == 1) begin
        mode_i      = ~m;
        rows_i      = 16'd5;
        cols_i      = 16'd100;
        ld_i        = 16'd7;
        base_addr_i = 16'h1234;
        repeat_i    = 16'd3;
      end
      fifo_full = full_mask[c];
      @(negedge clk);
      incr_log[c] = fifo_incr;
      busy_log[c] = busy_o;
      done_log[c] = done_o;
      addr_log[c] = fifo_addr;
      if (fifo_incr) begin
        obs_q.push_back(fifo_addr);
        obs_cyc.push_back(c);
      end
      if (done_o && done_cyc < 0) done_cyc = c;
      if (done_cyc >= 0 && c == done_cyc + 1) break;
    end
    start_i   = 1'b0;
    reset     = 1'b0;
    fifo_full = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    n_checks++;
    if (fifo_addr !== 16'h0) begin
      n_fail++;
      $display("FAIL reset_addr got %h want 0000", fifo_addr);
    end
    n_checks++;
    if (fifo_incr !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_incr got %b want 0", fifo_incr);
    end
    n_checks++;
    if (busy_o !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_busy got %b want 0", busy_o);
    end
    n_checks++;
    if (done_o !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_done got %b want 0", done_o);
    end
    reset = 1'b0;
  endtask

  task automatic test_mode0();
    logic [AW-1:0] a, e;
    int c, k;
    push_model(1'b0, 3, 64, 64, 'h100, 1);
    run(1'b0, 3, 64, 64, 'h100, 1, 64'h0, -1, -1, 40);
    k = 0;
    while (obs_q.size() > 0) begin
      a = obs_q.pop_front();
      c = obs_cyc.pop_front();
      k++;
      e = (exp_q.size() > 0) ? exp_q.pop_front() : 'x;
      n_checks++;
      if (a !== e || c != k) begin
        n_fail++;
        $display("FAIL mode0_push%0d got %h@%0d want %h@%0d", k, a, c, e, k);
      end
    end
    n_checks++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL mode0_count missing %0d want 0", exp_q.size());
    end
    n_checks++;
    if (done_cyc != 7) begin
      n_fail++;
      $display("FAIL mode0_done got cycle %0d want 7", done_cyc);
    end
    n_checks++;
    if (busy_log[8] !== 1'b0 || busy_log[7] !== 1'b1) begin
      n_fail++;
      $display("FAIL mode0_busy got %b%b want 10", busy_log[7], busy_log[8]);
    end
    exp_q.delete();
  endtask

  task automatic test_mode1();
    logic [AW-1:0] a, e;
    push_model(1'b1, 3, 64, 64, 'h100, 1);
    run(1'b1, 3, 64, 64, 'h100, 1, 64'h0, -1, -1, 40);
    while (obs_q.size() > 0) begin
      a = obs_q.pop_front();
      void'(obs_cyc.pop_front());
      e = (exp_q.size() > 0) ? exp_q.pop_front() : 'x;
      n_checks++;
      if (a !== e) begin
        n_fail++;
        $display("FAIL mode1_addr got %h want %h", a, e);
      end
    end
    n_checks++;
    if (exp_q.size() != 0 || done_cyc != 7) begin
      n_fail++;
      $display("FAIL mode1_end got missing=%0d done=%0d want 0,7",
               exp_q.size(), done_cyc);
    end
    exp_q.delete();
  endtask

  task automatic test_backpressure();
    logic [AW-1:0] a, e;
    int c, k;
    int want_cyc[6] = '{1, 5, 6, 7, 8, 9};
    push_model(1'b0, 3, 64, 64, 'h100, 1);
    run(1'b0, 3, 64, 64, 'h100, 1, 64'h1C, -1, -1, 40);
    for (int i = 2; i <= 4; i++) begin
      n_checks++;
      if (incr_log[i] !== 1'b0 || addr_log[i] !== 16'h140) begin
        n_fail++;
        $display("FAIL bp_hold c%0d got incr=%b addr=%h want 0,0140",
                 i, incr_log[i], addr_log[i]);
      end
    end
    k = 0;
    while (obs_q.size() > 0) begin
      a = obs_q.pop_front();
      c = obs_cyc.pop_front();
      e = (exp_q.size() > 0) ? exp_q.pop_front() : 'x;
      n_checks++;
      if (a !== e || k > 5 || c != want_cyc[k > 5 ? 5 : k]) begin
        n_fail++;
        $display("FAIL bp_push%0d got %h@%0d want %h@%0d",
                 k, a, c, e, want_cyc[k > 5 ? 5 : k]);
      end
      k++;
    end
    n_checks++;
    if (exp_q.size() != 0 || done_cyc != 10) begin
      n_fail++;
      $display("FAIL bp_end got missing=%0d done=%0d want 0,10",
               exp_q.size(), done_cyc);
    end
    exp_q.delete();
  endtask

  task automatic test_partial_tile();
    logic [AW-1:0] a, e;
    int n;
    for (int rep = 0; rep <= 2; rep += 2) begin
      push_model(1'b0, 2, 40, 40, 0, rep);
      run(1'b0, 2, 40, 40, 0, rep, 64'h0, -1, -1, 40);
      n = obs_q.size();
      while (obs_q.size() > 0) begin
        a = obs_q.pop_front();
        void'(obs_cyc.pop_front());
        e = (exp_q.size() > 0) ? exp_q.pop_front() : 'x;
        n_checks++;
        if (a !== e) begin
          n_fail++;
          $display("FAIL tile_rep%0d_addr got %h want %h", rep, a, e);
        end
      end
      n_checks++;
      if (n != (rep == 0 ? 4 : 8) || done_cyc != n + 1) begin
        n_fail++;
        $display("FAIL tile_rep%0d_count got %0d done=%0d want %0d",
                 rep, n, done_cyc, rep == 0 ? 4 : 8);
      end
      exp_q.delete();
    end
  endtask

  task automatic test_empty_and_wrap();
    logic [AW-1:0] a, e;
    run(1'b0, 0, 64, 64, 'h100, 1, 64'h0, -1, -1, 10);
    n_checks++;
    if (obs_q.size() != 0 || done_cyc != 1) begin
      n_fail++;
      $display("FAIL rows0 got pushes=%0d done=%0d want 0,1",
               obs_q.size(), done_cyc);
    end
    run(1'b1, 4, 0, 64, 'h100, 1, 64'h0, -1, -1, 10);
    n_checks++;
    if (obs_q.size() != 0 || done_cyc != 1) begin
      n_fail++;
      $display("FAIL cols0 got pushes=%0d done=%0d want 0,1",
               obs_q.size(), done_cyc);
    end
    push_model(1'b0, 2, 32, 32, 'hFFE0, 1);
    run(1'b0, 2, 32, 32, 'hFFE0, 1, 64'h0, -1, -1, 20);
    while (obs_q.size() > 0) begin
      a = obs_q.pop_front();
      void'(obs_cyc.pop_front());
      e = (exp_q.size() > 0) ? exp_q.pop_front() : 'x;
      n_checks++;
      if (a !== e) begin
        n_fail++;
        $display("FAIL wrap_addr got %h want %h", a, e);
      end
    end
    n_checks++;
    if (exp_q.size() != 0 || done_cyc != 3) begin
      n_fail++;
      $display("FAIL wrap_end got missing=%0d done=%0d want 0,3",
               exp_q.size(), done_cyc);
    end
    exp_q.delete();
  endtask

  task automatic test_reset_abort();
    logic [AW-1:0] a, e;
    push_model(1'b0, 3, 64, 64, 'h100, 1);
    run(1'b0, 3, 64, 64, 'h100, 1, 64'h0, 3, 2, 8);
    n_checks++;
    if (obs_q.size() != 3) begin
      n_fail++;
      $display("FAIL abort_pushes got %0d want 3", obs_q.size());
    end
    while (obs_q.size() > 0) begin
      a = obs_q.pop_front();
      void'(obs_cyc.pop_front());
      e = exp_q.pop_front();
      n_checks++;
      if (a !== e) begin
        n_fail++;
        $display("FAIL abort_addr got %h want %h", a, e);
      end
    end
    exp_q.delete();
    for (int i = 4; i <= 7; i++) begin
      n_checks++;
      if (incr_log[i] !== 1'b0 || busy_log[i] !== 1'b0 ||
          done_log[i] !== 1'b0) begin
        n_fail++;
        $display("FAIL abort_idle c%0d got incr=%b busy=%b done=%b want 000",
                 i, incr_log[i], busy_log[i], done_log[i]);
      end
    end
    push_model(1'b0, 3, 64, 64, 'h100, 1);
    run(1'b0, 3, 64, 64, 'h100, 1, 64'h0, -1, 3, 40);
    while (obs_q.size() > 0) begin
      a = obs_q.pop_front();
      void'(obs_cyc.pop_front());
      e = (exp_q.size() > 0) ? exp_q.pop_front() : 'x;
      n_checks++;
      if (a !== e) begin
        n_fail++;
        $display("FAIL replay_addr got %h want %h", a, e);
      end
    end
    n_checks++;
    if (exp_q.size() != 0 || done_cyc != 7 || busy_log[8] !== 1'b0) begin
      n_fail++;
      $display("FAIL replay_end got missing=%0d done=%0d busy8=%b want 0,7,0",
               exp_q.size(), done_cyc, busy_log[8]);
    end
    exp_q.delete();
  endtask

  task automatic test_random_full();
    logic [AW-1:0] a, e;
    logic [63:0] mask;
    int c, last_c;
    mask = {$urandom, $urandom} & 64'h0000_00FF_FFFF_FFFE;
    push_model(1'b1, 3, 70, 80, 'h200, 2);
    run(1'b1, 3, 70, 80, 'h200, 2, mask, -1, -1, 64);
    last_c = -1;
    while (obs_q.size() > 0) begin
      a = obs_q.pop_front();
      c = obs_cyc.pop_front();
      last_c = c;
      e = (exp_q.size() > 0) ? exp_q.pop_front() : 'x;
      n_checks++;
      if (a !== e || mask[c]) begin
        n_fail++;
        $display("FAIL rnd_push got %h@%0d full=%b want %h", a, c, mask[c], e);
      end
    end
    n_checks++;
    if (exp_q.size() != 0 || done_cyc != last_c + 1) begin
      n_fail++;
      $display("FAIL rnd_end got missing=%0d done=%0d want 0,%0d",
               exp_q.size(), done_cyc, last_c + 1);
    end
    exp_q.delete();
  endtask

  initial begin
    reset       = 1'b1;
    start_i     = 1'b0;
    mode_i      = 1'b0;
    rows_i      = '0;
    cols_i      = '0;
    ld_i        = '0;
    repeat_i    = '0;
    base_addr_i = '0;
    fifo_full   = 1'b0;
    test_reset();
    test_mode0();
    test_mode1();
    test_backpressure();
    test_partial_tile();
    test_empty_and_wrap();
    test_reset_abort();
    test_random_full();
    repeat (2) @(posedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_checks, n_fail);
    $finish;
  end

endmodule
